// File: rtl/uart_fifo_ctrl_pkg.sv
// uart_fifo_ctrl_pkg: register map, STATUS/CTRL bit positions and TX FSM states for uart_fifo_ctrl.
package uart_fifo_ctrl_pkg;
  typedef enum logic [1:0] {ADDR_STATUS, ADDR_DATA, ADDR_CTRL, ADDR_LEVEL} addr_e;
  typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_WAIT_END} tx_state_e;
  localparam logic READ = 1'b1;
  localparam int ST_RX_BUSY = 0;
  localparam int ST_TX_BUSY = 1;
  localparam int ST_RX_NEMPTY = 2;
  localparam int ST_TX_FULL = 3;
  localparam int ST_RX_OVF = 4;
  localparam int ST_TX_OVF = 5;
  localparam int CT_IE_RX = 0;
  localparam int CT_IE_TX = 1;
  localparam int CT_RX_FLUSH = 2;
  localparam int CT_TX_FLUSH = 3;
  localparam int CT_THRESH_LSB = 8;
  // A threshold of 0 behaves as 1 so an empty FIFO never raises irq_rx.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction
endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush; push while full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  assign empty = (r_count == '0);
  assign full = (r_count == CW'(DEPTH));
  assign w_pop = pop & !empty;
  assign w_push = push & (!full | w_pop);
  assign dout = r_mem[r_rd];
  assign count = r_count;
  always_ff @(posedge clk) begin
    if (w_push & !flush & !reset) r_mem[r_wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: CPU bus register file with TX/RX FIFOs, overflow flags, levels and interrupts
// sitting between the bus and the uart_tx/uart_rx serialisers.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter logic [7:0] RX_THRESH_RST = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq_rx,
  output logic        irq_tx,
  input  logic        rx_busy,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  input  logic        tx_end,
  output logic        tx_start,
  output logic [7:0]  tx_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_e r_state;
  logic [31:0] r_rd_data, w_rd_val;
  logic r_rdy_, r_irq_rx, r_irq_tx, r_tx_start;
  logic [7:0] r_tx_data, r_thresh;
  logic r_ie_rx, r_ie_tx, r_rx_ovf, r_tx_ovf;
  logic w_acc, w_rd, w_wr, w_unused;
  addr_e w_addr;
  logic w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
  logic w_st_wr, w_ctrl_wr;
  logic [7:0] w_rx_dout, w_tx_dout;
  logic [CW-1:0] w_rx_count, w_tx_count;
  assign w_unused = ^wr_data[31:16];
  assign w_addr = addr_e'(addr);
  assign w_acc = !cs_ & !as_;
  assign w_rd = w_acc & (rw == READ);
  assign w_wr = w_acc & (rw != READ);
  assign w_st_wr = w_wr & (w_addr == ADDR_STATUS);
  assign w_ctrl_wr = w_wr & (w_addr == ADDR_CTRL);
  assign w_rx_pop = w_rd & (w_addr == ADDR_DATA) & !w_rx_empty;
  assign w_rx_flush = w_ctrl_wr & wr_data[CT_RX_FLUSH];
  assign w_tx_push = w_wr & (w_addr == ADDR_DATA);
  assign w_tx_flush = w_ctrl_wr & wr_data[CT_TX_FLUSH];
  assign w_tx_pop = (r_state == TX_IDLE) & !w_tx_empty & !tx_busy;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_end), .pop(w_rx_pop), .flush(w_rx_flush),
    .din(rx_data), .dout(w_rx_dout), .count(w_rx_count), .full(w_rx_full), .empty(w_rx_empty)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(w_tx_push), .pop(w_tx_pop), .flush(w_tx_flush),
    .din(wr_data[7:0]), .dout(w_tx_dout), .count(w_tx_count), .full(w_tx_full), .empty(w_tx_empty)
  );
  always_comb begin
    w_rd_val = '0;
    case (w_addr)
      ADDR_STATUS: w_rd_val = {26'd0, r_tx_ovf, r_rx_ovf, w_tx_full, !w_rx_empty,
                               tx_busy | (r_state != TX_IDLE), rx_busy};
      ADDR_DATA:   w_rd_val = {24'd0, w_rx_empty ? 8'd0 : w_rx_dout};
      ADDR_CTRL:   w_rd_val = {16'd0, r_thresh, 6'd0, r_ie_tx, r_ie_rx};
      default:     w_rd_val = {7'd0, 9'(w_tx_count), 7'd0, 9'(w_rx_count)};
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rdy_ <= 1'b1;
      r_ie_rx <= 1'b0;
      r_ie_tx <= 1'b0;
      r_thresh <= RX_THRESH_RST;
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_irq_rx <= 1'b0;
      r_irq_tx <= 1'b0;
    end else begin
      r_rdy_ <= !w_acc;
      r_rd_data <= w_rd ? w_rd_val : '0;
      if (w_ctrl_wr) begin
        r_ie_rx <= wr_data[CT_IE_RX];
        r_ie_tx <= wr_data[CT_IE_TX];
        r_thresh <= wr_data[CT_THRESH_LSB +: 8];
      end
      // A new overflow in the same cycle as its W1C clear stays visible.
      r_rx_ovf <= (rx_end & w_rx_full & !w_rx_pop & !w_rx_flush) |
                  (r_rx_ovf & !(w_st_wr & wr_data[ST_RX_OVF]));
      r_tx_ovf <= (w_tx_push & w_tx_full & !w_tx_pop & !w_tx_flush) |
                  (r_tx_ovf & !(w_st_wr & wr_data[ST_TX_OVF]));
      r_irq_rx <= r_ie_rx & (9'(w_rx_count) >= {1'b0, eff_thresh(r_thresh)});
      r_irq_tx <= r_ie_tx & w_tx_empty & (r_state == TX_IDLE);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        TX_IDLE: if (w_tx_pop) begin
          r_state <= TX_LAUNCH;
          r_tx_start <= 1'b1;
          r_tx_data <= w_tx_dout;
        end
        TX_LAUNCH: begin
          r_state <= TX_WAIT_END;
          r_tx_start <= 1'b0;
        end
        TX_WAIT_END: if (tx_end) r_state <= TX_IDLE;
        default: r_state <= TX_IDLE;
      endcase
    end
  end
  assign rd_data = r_rd_data;
  assign rdy_ = r_rdy_;
  assign irq_rx = r_irq_rx;
  assign irq_tx = r_irq_tx;
  assign tx_start = r_tx_start;
  assign tx_data = r_tx_data;
endmodule
